// File: rtl/or1k_wb_arbiter.sv
// Two-master Wishbone arbiter: CPU instruction (i) and data (d) ports share one system bus.
// Round-robin on ties, bursts held to completion, watchdog turns a silent slave into a bus error.
module or1k_wb_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [ADDR_WIDTH-1:0]   i_adr_i,
   input  logic [DATA_WIDTH-1:0]   i_dat_i,
   input  logic [DATA_WIDTH/8-1:0] i_sel_i,
   input  logic                    i_cyc_i,
   input  logic                    i_stb_i,
   input  logic                    i_we_i,
   input  logic [2:0]              i_cti_i,
   input  logic [1:0]              i_bte_i,
   output logic                    i_ack_o,
   output logic                    i_err_o,
   output logic                    i_rty_o,
   output logic [DATA_WIDTH-1:0]   i_dat_o,

   input  logic [ADDR_WIDTH-1:0]   d_adr_i,
   input  logic [DATA_WIDTH-1:0]   d_dat_i,
   input  logic [DATA_WIDTH/8-1:0] d_sel_i,
   input  logic                    d_cyc_i,
   input  logic                    d_stb_i,
   input  logic                    d_we_i,
   input  logic [2:0]              d_cti_i,
   input  logic [1:0]              d_bte_i,
   output logic                    d_ack_o,
   output logic                    d_err_o,
   output logic                    d_rty_o,
   output logic [DATA_WIDTH-1:0]   d_dat_o,

   output logic [ADDR_WIDTH-1:0]   m_adr_o,
   output logic [DATA_WIDTH-1:0]   m_dat_o,
   output logic [DATA_WIDTH/8-1:0] m_sel_o,
   output logic                    m_cyc_o,
   output logic                    m_stb_o,
   output logic                    m_we_o,
   output logic [2:0]              m_cti_o,
   output logic [1:0]              m_bte_o,
   input  logic                    m_ack_i,
   input  logic                    m_err_i,
   input  logic                    m_rty_i,
   input  logic [DATA_WIDTH-1:0]   m_dat_i,

   output logic [1:0]              grant_o,
   output logic                    timeout_o
);

   localparam logic [7:0] TO = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   adr;
      logic [DATA_WIDTH-1:0]   dat;
      logic [DATA_WIDTH/8-1:0] sel;
      logic                    cyc;
      logic                    stb;
      logic                    we;
      logic [2:0]              cti;
      logic [1:0]              bte;
   } req_t;

   state_t     state;
   logic       last_d;
   logic [7:0] cnt;
   logic       abort;

   req_t ireq, dreq, own;
   logic own_i, own_d, live, route, fire, resp_ok;

   always_comb begin
      ireq.adr = i_adr_i; ireq.dat = i_dat_i; ireq.sel = i_sel_i; ireq.cyc = i_cyc_i;
      ireq.stb = i_stb_i; ireq.we  = i_we_i;  ireq.cti = i_cti_i; ireq.bte = i_bte_i;
      dreq.adr = d_adr_i; dreq.dat = d_dat_i; dreq.sel = d_sel_i; dreq.cyc = d_cyc_i;
      dreq.stb = d_stb_i; dreq.we  = d_we_i;  dreq.cti = d_cti_i; dreq.bte = d_bte_i;
   end

   assign own_i = (state == GNT_I);
   assign own_d = (state == GNT_D);

   always_comb begin
      own = '0;
      if (own_d)      own = dreq;
      else if (own_i) own = ireq;
   end

   // abort holds the bus dead after a watchdog fire until the owner ends its cycle,
   // so a late slave response cannot be mistaken for the start of a new transfer.
   assign live    = (state != IDLE) && !rst && !abort;
   assign route   = live && own.cyc;
   assign fire    = route && (cnt == TO);
   assign resp_ok = route && !fire;

   assign m_adr_o = own.adr;
   assign m_dat_o = own.dat;
   assign m_sel_o = own.sel;
   assign m_we_o  = own.we;
   assign m_cti_o = own.cti;
   assign m_bte_o = own.bte;
   assign m_cyc_o = route && !fire;
   assign m_stb_o = m_cyc_o && own.stb;

   assign i_ack_o = own_i && resp_ok && m_ack_i;
   assign i_rty_o = own_i && resp_ok && m_rty_i;
   assign i_err_o = own_i && route && (fire || m_err_i);
   assign d_ack_o = own_d && resp_ok && m_ack_i;
   assign d_rty_o = own_d && resp_ok && m_rty_i;
   assign d_err_o = own_d && route && (fire || m_err_i);

   assign i_dat_o   = m_dat_i;
   assign d_dat_o   = m_dat_i;
   assign grant_o   = {own_d, own_i};
   assign timeout_o = fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_cyc_i && d_cyc_i) begin
                  state  <= last_d ? GNT_I : GNT_D;
                  last_d <= !last_d;
               end else if (d_cyc_i) begin
                  state  <= GNT_D;
                  last_d <= 1'b1;
               end else if (i_cyc_i) begin
                  state  <= GNT_I;
                  last_d <= 1'b0;
               end
            end
            GNT_I: if (!i_cyc_i) begin
               if (d_cyc_i) begin
                  state  <= GNT_D;
                  last_d <= 1'b1;
               end else begin
                  state  <= IDLE;
               end
            end
            GNT_D: if (!d_cyc_i) begin
               if (i_cyc_i) begin
                  state  <= GNT_I;
                  last_d <= 1'b0;
               end else begin
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 8'd0;
         abort <= 1'b0;
      end else begin
         if (fire || !(m_cyc_o && m_stb_o) || m_ack_i || m_err_i || m_rty_i)
            cnt <= 8'd0;
         else
            cnt <= cnt + 8'd1;
         abort <= (fire || abort) && own.cyc;
      end
   end

endmodule

// File: tb/tb_or1k_wb_arbiter.sv
// Directed bench for or1k_wb_arbiter: grant latency, tie-break, bursts, watchdog, reset abort.
// Inputs change just after the falling edge; outputs are sampled 1ns later, well clear of posedge.
module tb_or1k_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_adr_i, i_dat_i, d_adr_i, d_dat_i, m_dat_i;
   logic [3:0]  i_sel_i, d_sel_i;
   logic        i_cyc_i, i_stb_i, i_we_i, d_cyc_i, d_stb_i, d_we_i;
   logic [2:0]  i_cti_i, d_cti_i;
   logic [1:0]  i_bte_i, d_bte_i;
   logic        i_ack_o, i_err_o, i_rty_o, d_ack_o, d_err_o, d_rty_o;
   logic [31:0] i_dat_o, d_dat_o, m_adr_o, m_dat_o;
   logic [3:0]  m_sel_o;
   logic        m_cyc_o, m_stb_o, m_we_o;
   logic [2:0]  m_cti_o;
   logic [1:0]  m_bte_o;
   logic        m_ack_i, m_err_i, m_rty_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   logic man_ack, auto_ack;
   int   nvec = 0, nerr = 0;
   int   ni, nd;

   // simple slave: zero-wait ack on every strobe when auto_ack is on
   assign m_ack_i = man_ack | (auto_ack & m_cyc_o & m_stb_o);

   always #5 clk = ~clk;

   or1k_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_adr_i(i_adr_i), .i_dat_i(i_dat_i), .i_sel_i(i_sel_i), .i_cyc_i(i_cyc_i),
      .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_cti_i(i_cti_i), .i_bte_i(i_bte_i),
      .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_rty_o(i_rty_o), .i_dat_o(i_dat_o),
      .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_cyc_i(d_cyc_i),
      .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_cti_i(d_cti_i), .d_bte_i(d_bte_i),
      .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rty_o(d_rty_o), .d_dat_o(d_dat_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o),
      .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
      .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i), .m_dat_i(m_dat_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   task automatic clear_in();
      i_adr_i = '0; i_dat_i = '0; i_sel_i = '0; i_cyc_i = 0; i_stb_i = 0; i_we_i = 0;
      i_cti_i = '0; i_bte_i = '0;
      d_adr_i = '0; d_dat_i = '0; d_sel_i = '0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
      d_cti_i = '0; d_bte_i = '0;
      m_err_i = 0; m_rty_i = 0; m_dat_i = '0; man_ack = 0; auto_ack = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_mcyc", m_cyc_o, 0);
      chk("rst_mstb", m_stb_o, 0);
      chk("rst_tmo", timeout_o, 0);
      chk("rst_acks", {i_ack_o, i_err_o, i_rty_o, d_ack_o, d_err_o, d_rty_o}, 6'b0);
      nc();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired want done");
      $fatal(1, "time limit");
   end

   initial begin
      do_reset();

      // single data request: 1-cycle grant latency and full routing
      d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h1000_0040; d_dat_i = 32'hCAFE_0001;
      d_sel_i = 4'hF; d_we_i = 1; d_cti_i = 3'b000; m_dat_i = 32'h1234_5678;
      #1;
      chk("t1_lat_grant", grant_o, 2'b00);
      chk("t1_lat_mcyc", m_cyc_o, 0);
      nc(); #1;
      chk("t1_grant", grant_o, 2'b10);
      chk("t1_madr", m_adr_o, 32'h1000_0040);
      chk("t1_mdat", m_dat_o, 32'hCAFE_0001);
      chk("t1_msel_we", {m_sel_o, m_we_o}, 5'b11111);
      chk("t1_mcycstb", {m_cyc_o, m_stb_o}, 2'b11);
      chk("t1_dack_lo", d_ack_o, 0);
      man_ack = 1; #1;
      chk("t1_dack", d_ack_o, 1);
      chk("t1_iack", i_ack_o, 0);
      chk("t1_idat", i_dat_o, 32'h1234_5678);
      chk("t1_ddat", d_dat_o, 32'h1234_5678);
      nc();
      man_ack = 0; d_cyc_i = 0; d_stb_i = 0; #1;
      chk("t1_cyc_drop_grant", grant_o, 2'b10);
      chk("t1_cyc_drop_mcyc", {m_cyc_o, m_stb_o}, 2'b00);
      nc(); #1;
      chk("t1_idle", grant_o, 2'b00);

      // simultaneous requests after reset: data first, then instruction with no idle gap
      do_reset();
      auto_ack = 1;
      i_cyc_i = 1; i_stb_i = 1; i_adr_i = 32'h0000_0100;
      d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h2000_0000;
      nc(); #1;
      chk("t2_first", grant_o, 2'b10);
      chk("t2_dack", d_ack_o, 1);
      chk("t2_iack0", i_ack_o, 0);
      d_cyc_i = 0; d_stb_i = 0;
      nc(); #1;
      chk("t2_handover", grant_o, 2'b01);
      chk("t2_madr", m_adr_o, 32'h0000_0100);
      chk("t2_iack", i_ack_o, 1);
      i_cyc_i = 0; i_stb_i = 0;
      nc(); #1;
      chk("t2_idle", grant_o, 2'b00);

      // instruction 4-beat burst is never split by a pending data request
      i_cyc_i = 1; i_stb_i = 1; i_cti_i = 3'b010; i_adr_i = 32'h0000_0200;
      for (int b = 0; b < 4; b++) begin
         nc();
         i_cti_i = (b == 3) ? 3'b111 : 3'b010;
         if (b == 0) begin d_cyc_i = 1; d_stb_i = 1; end
         #1;
         chk($sformatf("t3_grant_b%0d", b), grant_o, 2'b01);
         chk($sformatf("t3_iack_b%0d", b), i_ack_o, 1);
         chk($sformatf("t3_dack_b%0d", b), d_ack_o, 0);
         chk($sformatf("t3_cti_b%0d", b), m_cti_o, (b == 3) ? 3'b111 : 3'b010);
      end
      i_cyc_i = 0; i_stb_i = 0; i_cti_i = 3'b000;
      nc(); #1;
      chk("t3_to_data", grant_o, 2'b10);
      chk("t3_dack", d_ack_o, 1);
      d_cyc_i = 0; d_stb_i = 0;
      nc(); #1;
      chk("t3_idle", grant_o, 2'b00);

      // watchdog with TIMEOUT=4: fires on the 5th strobe cycle of a silent slave
      auto_ack = 0;
      i_cyc_i = 1; i_stb_i = 1; i_adr_i = 32'h0000_0300;
      for (int k = 1; k <= 4; k++) begin
         nc(); #1;
         chk($sformatf("t4_stb_c%0d", k), m_stb_o, 1);
         chk($sformatf("t4_err_c%0d", k), {i_err_o, timeout_o}, 2'b00);
      end
      nc(); #1;
      chk("t4_fire_err", i_err_o, 1);
      chk("t4_fire_tmo", timeout_o, 1);
      chk("t4_fire_stb", {m_cyc_o, m_stb_o}, 2'b00);
      chk("t4_fire_derr", d_err_o, 0);
      nc();
      man_ack = 1; #1;
      chk("t4_late_ack", {i_ack_o, d_ack_o}, 2'b00);
      chk("t4_tmo_pulse", timeout_o, 0);
      chk("t4_hold_grant", grant_o, 2'b01);
      nc();
      man_ack = 0; i_cyc_i = 0; i_stb_i = 0;
      nc(); #1;
      chk("t4_idle", grant_o, 2'b00);

      // reset during beat 2 of a data burst
      auto_ack = 1;
      d_cyc_i = 1; d_stb_i = 1; d_cti_i = 3'b010;
      nc(); #1;
      chk("t5_beat1", {grant_o, d_ack_o}, 3'b101);
      nc();
      rst = 1;
      nc(); #1;
      chk("t5_grant", grant_o, 2'b00);
      chk("t5_mcyc", m_cyc_o, 0);
      chk("t5_dack", d_ack_o, 0);
      rst = 0;
      nc(); #1;
      chk("t5_resume", grant_o, 2'b10);
      d_cyc_i = 0; d_stb_i = 0; d_cti_i = 3'b000;
      nc(); #1;
      chk("t5_idle", grant_o, 2'b00);

      // 10 transactions from repeated simultaneous requests alternate D, I, ...
      do_reset();
      auto_ack = 1;
      ni = 0; nd = 0;
      for (int r = 0; r < 5; r++) begin
         i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
         nc(); #1;
         chk($sformatf("t6_r%0d_d", r), grant_o, 2'b10);
         chk($sformatf("t6_r%0d_d_iack", r), i_ack_o, 0);
         if (grant_o == 2'b10) nd++;
         if (grant_o == 2'b01) ni++;
         d_cyc_i = 0; d_stb_i = 0;
         nc(); #1;
         chk($sformatf("t6_r%0d_i", r), grant_o, 2'b01);
         chk($sformatf("t6_r%0d_i_dack", r), d_ack_o, 0);
         if (grant_o == 2'b10) nd++;
         if (grant_o == 2'b01) ni++;
         i_cyc_i = 0; i_stb_i = 0;
         nc(); #1;
         chk($sformatf("t6_r%0d_idle", r), grant_o, 2'b00);
      end
      chk("t6_count_d", nd, 5);
      chk("t6_count_i", ni, 5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
